cpu_bus_uart_tx: RTL and testbench

Memory-mapped serial transmit peripheral that sits on the RISC CPU's external bus as a responder, alongside the test RAM and ROM. The CPU writes bytes to a register window. The block queues them in a small FIFO and shifts them out on a UART 8N1 line. The CPU can read back status and control registers over the same bidirectional data bus.

---
 rtl/cpu_bus_uart_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_bus_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_uart_tx.sv
// cpu_bus_uart_tx: memory-mapped UART 8N1 transmitter on the CPU external bus.
// Four-byte register window (TXDATA, STATUS, CTRL, DIVISOR). Bytes written to
// TXDATA are queued in a small circular FIFO and shifted out LSB first.
module cpu_bus_uart_tx #(
    parameter logic [12:0] BASE_ADDR  = 13'h1F00,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  DIV_RESET  = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] addr,
    inout  logic [7:0]  data,
    input  logic        rd,
    input  logic        wr,
    output logic        tx,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Bus decode
    logic       sel;
    logic [1:0] reg_sel;
    logic       wr_d;
    logic       wr_pulse;
    logic       push_req;
    logic       bus_drive;
    logic [7:0] rdata;

    // Control/status registers
    logic       ctrl_en;
    logic       ctrl_ie;
    logic       ovf;
    logic [7:0] divisor;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_ok;
    logic          pop;

    // Transmit FSM
    tx_state_t state, state_n;
    logic [7:0] baud_cnt, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shift, shift_n;

    assign sel        = (addr[12:2] == BASE_ADDR[12:2]);
    assign reg_sel    = addr[1:0];
    assign wr_pulse   = wr & ~wr_d & sel;
    assign push_req   = wr_pulse && (reg_sel == 2'd0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign bus_drive  = rd & sel & ~wr;

    // Register the write strobe so a held wr produces exactly one action.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_d <= 1'b0;
        end else begin
            wr_d <= wr;
        end
    end

    // CTRL, DIVISOR and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en <= 1'b0;
            ctrl_ie <= 1'b0;
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
        end else begin
            if (wr_pulse && (reg_sel == 2'd2)) begin
                ctrl_en <= data[0];
                ctrl_ie <= data[1];
            end
            if (wr_pulse && (reg_sel == 2'd3)) begin
                divisor <= data;
            end
            if (push_req && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_pulse && (reg_sel == 2'd2) && data[7]) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
        end
    end

    // Next-state logic; DIVISOR is reloaded at each bit start.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ctrl_en && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    baud_n  = divisor;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == '0) begin
                    baud_n  = divisor;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt - 8'd1;
                end
            end
            S_DATA: begin
                if (baud_cnt == '0) begin
                    baud_n  = divisor;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt - 8'd1;
                end
            end
            S_STOP: begin
                if (baud_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud_cnt - 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Serial line level follows the FSM state directly.
    always_comb begin
        tx = 1'b1;
        if (state == S_START) begin
            tx = 1'b0;
        end else if (state == S_DATA) begin
            tx = shift[0];
        end
    end

    // Interrupt: FIFO drained, transmitter idle and interrupts enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= ctrl_ie && fifo_empty && (state == S_IDLE);
        end
    end

    // Read-back multiplexer.
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            2'd0: rdata = '0;
            2'd1: rdata = {4'b0000, ovf, (state != S_IDLE), fifo_full, fifo_empty};
            2'd2: rdata = {6'b000000, ctrl_ie, ctrl_en};
            2'd3: rdata = divisor;
            default: rdata = '0;
        endcase
    end

    assign data = bus_drive ? rdata : 'z;

endmodule

// File: tb/tb_cpu_bus_uart_tx.sv
// Testbench for cpu_bus_uart_tx: directed bus transactions plus a frame-level
// model of the serial line and interrupt compared on every clock.
module tb_cpu_bus_uart_tx;

    localparam logic [12:0] A_TX  = 13'h1F00;
    localparam logic [12:0] A_ST  = 13'h1F01;
    localparam logic [12:0] A_CT  = 13'h1F02;
    localparam logic [12:0] A_DV  = 13'h1F03;
    localparam logic [12:0] BASE  = 13'h1F00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  drv = '0;
    logic        drv_oe = 1'b0;
    wire  [7:0]  data;
    wire         tx;
    wire         irq;

    int checks = 0;
    int failures = 0;

    assign data = drv_oe ? drv : 'z;

    always #5 clk = ~clk;

    cpu_bus_uart_tx #(
        .BASE_ADDR (13'h1F00),
        .FIFO_DEPTH(4),
        .DIV_RESET (8'd3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .addr(addr),
        .data(data),
        .rd  (rd),
        .wr  (wr),
        .tx  (tx),
        .irq (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each transmitted byte becomes a list of per-clock line levels; the
    // transmitter is busy while that list is non-empty.
    logic [7:0] m_q[$];
    bit         m_frame[$];
    logic [7:0] m_sent[$];
    bit         m_en, m_ie, m_ovf, m_irq, m_wr_d;
    logic [7:0] m_div;
    int         m_frames;

    function automatic bit m_tx();
        return (m_frame.size() != 0) ? m_frame[0] : 1'b1;
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0000, m_ovf, (m_frame.size() != 0), (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    task automatic model_step();
        bit idle_now;
        bit irq_next;
        logic [7:0] b;
        if (!rst) begin
            m_q.delete();
            m_frame.delete();
            m_en   = 1'b0;
            m_ie   = 1'b0;
            m_ovf  = 1'b0;
            m_irq  = 1'b0;
            m_wr_d = 1'b0;
            m_div  = 8'd3;
            return;
        end
        idle_now = (m_frame.size() == 0);
        irq_next = m_ie && (m_q.size() == 0) && idle_now;
        if (!idle_now) begin
            void'(m_frame.pop_front());
        end else if (m_en && (m_q.size() != 0)) begin
            b = m_q.pop_front();
            m_sent.push_back(b);
            m_frames++;
            for (int bitpos = 0; bitpos < 10; bitpos++) begin
                for (int k = 0; k <= int'(m_div); k++) begin
                    if (bitpos == 0)      m_frame.push_back(1'b0);
                    else if (bitpos == 9) m_frame.push_back(1'b1);
                    else                  m_frame.push_back(b[bitpos-1]);
                end
            end
        end
        if (wr && !m_wr_d && (addr[12:2] == BASE[12:2])) begin
            case (addr[1:0])
                2'd0: if (m_q.size() < DEPTH) m_q.push_back(data); else m_ovf = 1'b1;
                2'd2: begin
                    m_en = data[0];
                    m_ie = data[1];
                    if (data[7]) m_ovf = 1'b0;
                end
                2'd3: m_div = data;
                default: ;
            endcase
        end
        m_wr_d = wr;
        m_irq  = irq_next;
    endtask

    // Compare process: advance the model one clock, then check line and irq.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("tx_line", tx, m_tx());
            chk("irq_line", irq, m_irq);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [12:0] a, input logic [7:0] d, input int hold = 1);
        @(negedge clk);
        #1;
        addr   = a;
        drv    = d;
        drv_oe = 1'b1;
        wr     = 1'b1;
        repeat (hold) @(negedge clk);
        #1;
        wr     = 1'b0;
        drv_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [12:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        #1;
        addr = a;
        rd   = 1'b1;
        #1;
        chk(name, data, exp);
        if (a == A_ST) chk("status_vs_model", data, m_status());
        #1;
        rd = 1'b0;
    endtask

    task automatic wait_model_idle(input int budget);
        int i;
        i = 0;
        while (((m_frame.size() != 0) || (m_q.size() != 0)) && (i < budget)) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("drain_timeout", ((m_frame.size() == 0) && (m_q.size() == 0)), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [9:0] seq;
        logic [7:0] bv;
        bit         found;
        int         n;
        int         f0;

        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_irq", irq, 0);
        #1 rst = 1'b1;

        // Reset values and bus release
        bus_read(A_ST, 8'h01, "status_reset");
        bus_read(A_DV, 8'h03, "div_reset");
        bus_read(A_CT, 8'h00, "ctrl_reset");
        bus_read(A_TX, 8'h00, "txdata_reads_zero");
        @(negedge clk);
        #1;
        addr = A_ST; rd = 1'b0; drv = 8'hA5; drv_oe = 1'b1;
        #1 chk("released_rd0", data, 8'hA5);
        addr = 13'h1F04; rd = 1'b1; drv = 8'h5A;
        #1 chk("released_unselected", data, 8'h5A);
        rd = 1'b0; drv_oe = 1'b0;
        chk("idle_tx", tx, 1);

        // One byte at one clock per bit
        bus_write(A_DV, 8'h00);
        bus_write(A_CT, 8'h01);
        bus_write(A_TX, 8'hA5);
        addr = A_ST; rd = 1'b1;
        seq = 10'b1101001010;
        found = 1'b0;
        for (int i = 0; (i < 20) && !found; i++) begin
            @(negedge clk);
            #1;
            if (tx == 1'b0) found = 1'b1;
        end
        chk("a5_start_seen", found, 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk("a5_bit", tx, seq[i]);
            chk("a5_status_busy", data, 8'h05);
        end
        @(negedge clk);
        #1 chk("a5_status_after", data, 8'h01);
        rd = 1'b0;

        // Held write strobe pushes once; unselected write is ignored
        bus_write(A_CT, 8'h00);
        bus_write(A_TX, 8'h5A, 3);
        bus_read(A_ST, 8'h00, "single_push_status");
        bus_write(13'h1F07, 8'h55);
        bus_read(A_DV, 8'h00, "unselected_write_ignored");
        f0 = m_frames;
        bus_write(A_CT, 8'h01);
        wait_model_idle(100);
        chk("single_push_frames", m_frames - f0, 1);
        bus_read(A_ST, 8'h01, "single_push_drained");

        // Overflow: five writes into four slots
        bus_write(A_CT, 8'h00);
        bv = 8'h11;
        for (int i = 0; i < 5; i++) begin
            bus_write(A_TX, bv);
            bv++;
        end
        bus_read(A_ST, 8'h0A, "full_ovf_status");
        m_sent.delete();
        f0 = m_frames;
        bus_write(A_CT, 8'h01);
        wait_model_idle(200);
        chk("ovf_frames", m_frames - f0, 4);
        bv = 8'h11;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_sent_order", (m_sent.size() > i) ? m_sent[i] : 8'hxx, bv);
            bv++;
        end
        bus_read(A_ST, 8'h09, "ovf_sticky");
        bus_write(A_CT, 8'h81);
        bus_read(A_ST, 8'h01, "ovf_cleared");
        bus_read(A_CT, 8'h01, "ctrl_bit7_reads_zero");

        // Interrupt and frame length at DIVISOR=3
        bus_write(A_DV, 8'h03);
        bus_write(A_CT, 8'h03);
        @(negedge clk);
        #1 chk("irq_idle_high", irq, 1);
        bus_write(A_TX, 8'h3C);
        addr = A_ST; rd = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; (i < 20) && (data[2] != 1'b1); i++) begin
            @(negedge clk);
            #1;
        end
        chk("irq_low_in_frame", irq, 0);
        n = 0;
        while ((data[2] == 1'b1) && (n < 200)) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("frame_len", n, 40);
        chk("irq_lags_busy", irq, 0);
        @(negedge clk);
        #1 chk("irq_after_frame", irq, 1);
        rd = 1'b0;

        // Reset in the middle of a two-byte queue
        bus_write(A_CT, 8'h02);
        bus_write(A_TX, 8'hC3);
        bus_write(A_TX, 8'h81);
        bus_write(A_CT, 8'h03);
        found = 1'b0;
        for (int i = 0; (i < 20) && !found; i++) begin
            @(negedge clk);
            #1;
            if (tx == 1'b0) found = 1'b1;
        end
        chk("rst_frame_started", found, 1);
        repeat (8) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_tx_immediate", tx, 1);
        chk("rst_irq_immediate", irq, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        bus_read(A_ST, 8'h01, "rst_status");
        bus_read(A_DV, 8'h03, "rst_div");
        bus_read(A_CT, 8'h00, "rst_ctrl");
        repeat (60) @(negedge clk);
        #1 chk("rst_no_frames", tx, 1);
        bus_read(A_ST, 8'h01, "rst_status_late");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
